// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core/host data memory arbiter with quota-limited alternating priority
module dmem_arbiter #(
    parameter int CORE_QUOTA = 4,
    parameter int HOST_QUOTA = 1
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_gnt,
    output logic [31:0] core_rdata,
    output logic        core_stall,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [31:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic        host_gnt,
    output logic [31:0] host_rdata,
    output logic        host_rvalid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    output logic [15:0] stall_count
);

    localparam logic [3:0] CQ = 4'(CORE_QUOTA);
    localparam logic [3:0] HQ = 4'(HOST_QUOTA);

    logic        prio_q, prio_d;
    logic [3:0]  run_q, run_d;
    logic [31:0] host_rdata_q, host_rdata_d;
    logic        host_rvalid_q, host_rvalid_d;
    logic [15:0] stall_count_q, stall_count_d;

    logic contended;
    logic core_win;
    logic host_win;
    logic [3:0] owner_quota;

    // Grants are suppressed during reset so nothing reaches memory.
    always_comb begin
        contended = core_req & host_req;
        core_win  = ~areset & core_req & (~host_req | ~prio_q);
        host_win  = ~areset & host_req & (~core_req | prio_q);
    end

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = core_addr;
        mem_wd   = core_wdata;
        if (core_win) begin
            mem_we = core_we;
        end else if (host_win) begin
            mem_we   = host_we;
            mem_addr = host_addr;
            mem_wd   = host_wdata;
        end
    end

    assign core_gnt    = core_win;
    assign host_gnt    = host_win;
    assign core_rdata  = mem_rd;
    assign core_stall  = ~areset & core_req & ~core_win;
    assign host_rdata  = host_rdata_q;
    assign host_rvalid = host_rvalid_q;
    assign stall_count = stall_count_q;

    always_comb begin
        owner_quota   = prio_q ? HQ : CQ;
        prio_d        = prio_q;
        run_d         = run_q;
        host_rdata_d  = host_rdata_q;
        host_rvalid_d = 1'b0;
        stall_count_d = stall_count_q;

        // Only contended cycles consume the owner's quota.
        if (contended) begin
            if (run_q + 4'd1 == owner_quota) begin
                prio_d = ~prio_q;
                run_d  = 4'd0;
            end else begin
                run_d = run_q + 4'd1;
            end
        end

        if (host_win && !host_we) begin
            host_rdata_d  = mem_rd;
            host_rvalid_d = 1'b1;
        end

        if (core_stall && stall_count_q != 16'hFFFF) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            prio_q        <= 1'b0;
            run_q         <= 4'd0;
            host_rdata_q  <= 32'd0;
            host_rvalid_q <= 1'b0;
            stall_count_q <= 16'd0;
        end else begin
            prio_q        <= prio_d;
            run_q         <= run_d;
            host_rdata_q  <= host_rdata_d;
            host_rvalid_q <= host_rvalid_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a behavioural model
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        areset, mem_clr;
    logic        core_req, core_we, host_req, host_we;
    logic [31:0] core_addr, core_wdata, host_addr, host_wdata;
    logic        core_gnt, core_stall, host_gnt, host_rvalid, mem_we;
    logic [31:0] core_rdata, host_rdata, mem_addr, mem_wd, mem_rd;
    logic [15:0] stall_count;

    logic        a_core_gnt, a_core_stall, a_host_gnt, a_host_rvalid, a_mem_we;
    logic [31:0] a_core_rdata, a_host_rdata, a_mem_addr, a_mem_wd;
    logic [31:0] a_mem_rd = 32'd0;
    logic [15:0] a_stall_count;

    dmem_arbiter u_dut (
        .clk(clk), .areset(areset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rdata(core_rdata), .core_stall(core_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .stall_count(stall_count)
    );

    dmem_arbiter #(.CORE_QUOTA(1), .HOST_QUOTA(1)) u_alt (
        .clk(clk), .areset(areset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(a_core_gnt), .core_rdata(a_core_rdata), .core_stall(a_core_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(a_host_gnt), .host_rdata(a_host_rdata), .host_rvalid(a_host_rvalid),
        .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wd(a_mem_wd), .mem_rd(a_mem_rd),
        .stall_count(a_stall_count)
    );

    // Data memory attached to the default-quota instance.
    logic [31:0] dmem [0:255];
    assign mem_rd = dmem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) dmem[i] <= 32'd0;
        end else if (mem_we) begin
            dmem[mem_addr[9:2]] <= mem_wd;
        end
    end

    typedef struct {
        logic        cg, hg, we, stall, rvalid, cchk, cg2, hg2;
        logic [31:0] addr, wd, rdata, cdata;
        logic [15:0] sc;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("core_gnt", core_gnt, e.cg);
            chk("host_gnt", host_gnt, e.hg);
            chk("mem_we", mem_we, e.we);
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_wd", mem_wd, e.wd);
            chk("core_stall", core_stall, e.stall);
            chk("host_rvalid", host_rvalid, e.rvalid);
            chk("host_rdata", host_rdata, e.rdata);
            chk("stall_count", stall_count, e.sc);
            if (e.cchk) chk("core_rdata", core_rdata, e.cdata);
            chk("alt_core_gnt", a_core_gnt, e.cg2);
            chk("alt_host_gnt", a_host_gnt, e.hg2);
        end
    end

    // Reference model: who owns priority and how many contended grants it has taken.
    bit          m_prio, a_prio, m_rv, last_hg;
    int          m_run, a_run, m_sc;
    logic [31:0] m_rd;
    logic [31:0] ref_mem [0:255];

    function automatic void pick(input bit cr, input bit hr, input bit owner_host, output bit cw, output bit hw);
        if (cr && hr) begin
            cw = !owner_host;
            hw = owner_host;
        end else begin
            cw = cr;
            hw = hr;
        end
    endfunction

    function automatic void take_quota(input int cq, input int hq, inout bit pr, inout int run);
        run = run + 1;
        if (run == (pr ? hq : cq)) begin
            pr  = !pr;
            run = 0;
        end
    endfunction

    task automatic model_reset();
        m_prio = 0; m_run = 0; a_prio = 0; a_run = 0;
        m_rv = 0; m_rd = 32'd0; m_sc = 0;
    endtask

    task automatic step(input bit rst, input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                        input bit hr, input bit hw, input logic [31:0] ha, input logic [31:0] hd);
        exp_t e;
        bit g1c, g1h, g2c, g2h;
        areset = rst; core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
        host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
        pick(cr, hr, m_prio, g1c, g1h);
        pick(cr, hr, a_prio, g2c, g2h);
        if (rst) begin g1c = 0; g1h = 0; g2c = 0; g2h = 0; end
        e.cg = g1c; e.hg = g1h; e.cg2 = g2c; e.hg2 = g2h;
        e.we    = g1c ? cw : (g1h ? hw : 1'b0);
        e.addr  = g1h ? ha : ca;
        e.wd    = g1h ? hd : cd;
        e.stall = !rst && cr && !g1c;
        e.rvalid = m_rv; e.rdata = m_rd; e.sc = 16'(m_sc);
        e.cchk = g1c; e.cdata = ref_mem[ca[9:2]];
        sb.push_back(e);
        @(posedge clk); #1;
        last_hg = g1h;
        if (rst) begin
            model_reset();
        end else begin
            m_rv = g1h && !hw;
            if (m_rv) m_rd = ref_mem[ha[9:2]];
            if (e.we) ref_mem[e.addr[9:2]] = e.wd;
            if (e.stall && m_sc < 65535) m_sc++;
            if (cr && hr) begin
                take_quota(4, 1, m_prio, m_run);
                take_quota(1, 1, a_prio, a_run);
            end
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    endtask

    bit          h_pend, h_we, c_req, rst_r;
    logic [31:0] h_addr, h_wd;

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
        areset = 1; mem_clr = 1;
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
        repeat (2) @(posedge clk);
        #1; mem_clr = 0;
        model_reset();

        // Reset state, then a core store and load-back.
        step(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        step(0, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0);
        step(0, 1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
        // Host write then read: rvalid in the following cycle only.
        step(0, 0, 0, 32'h0, 32'h0, 1, 1, 32'h20, 32'h12345678);
        step(0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h20, 32'h0);
        idle();
        idle();

        // Sustained contention from a fresh reset.
        step(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 32'h40, 32'h0, 1, 0, 32'h44, 32'h0);
        chk("stall_count_after_10", 32'(stall_count), 32'd2);
        // Contended writes to the same word: core owns priority here.
        step(0, 1, 1, 32'h30, 32'h1, 1, 1, 32'h30, 32'h2);
        chk("loser_write_blocked", dmem[12], 32'h1);
        step(0, 0, 0, 32'h0, 32'h0, 1, 1, 32'h30, 32'h2);
        chk("host_write_lands", dmem[12], 32'h2);
        // Alternation with a host-only cycle inserted.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 32'h8, 32'h0, 1, 0, 32'h30, 32'h0);
        step(0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h30, 32'h0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 32'h8, 32'h0, 1, 0, 32'h30, 32'h0);
        // Reset during a host read grant, and right after one.
        step(0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h20, 32'h0);
        step(1, 0, 0, 32'h0, 32'h0, 1, 0, 32'h20, 32'h0);
        idle();
        step(1, 1, 1, 32'h50, 32'h77, 1, 1, 32'h54, 32'h88);
        idle();

        // Randomized traffic; host keeps its request stable until granted.
        h_pend = 0; h_we = 0; h_addr = 0; h_wd = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!h_pend && $urandom_range(0, 2) != 0) begin
                h_pend = 1;
                h_we   = $urandom_range(0, 1) == 1;
                h_addr = 32'($urandom_range(0, 15)) << 2;
                h_wd   = $urandom;
            end
            c_req = $urandom_range(0, 3) != 0;
            rst_r = $urandom_range(0, 199) == 0;
            step(rst_r, c_req, $urandom_range(0, 1) == 1, 32'($urandom_range(0, 15)) << 2, $urandom,
                 h_pend, h_we, h_addr, h_wd);
            if (last_hg) h_pend = 0;
        end
        idle();

        for (int w = 0; w < 50 && sb.size() > 0; w++) @(posedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single data memory between the processor core (load/store path) and a host/debug port (program loader, memory inspection). It sits between the core's ALU-address/WriteData/MemWrite signals and data memory. It grants one requester per cycle using quota-limited alternating priority. A stall output freezes the program counter and suppresses register writeback while the core is waiting for the memory.

## Interface
- CORE_QUOTA, default 4: consecutive contended grants the core may take before priority passes to host; legal range 1..15.
- HOST_QUOTA, default 1: consecutive contended grants the host may take before priority returns to core; legal range 1..15.
- clk  in  1  system clock; all state updates on rising edge.
- areset  in  1  reset, synchronous, active-high.
- core_req  in  1  core requests a memory access this cycle (load or store).
- core_we  in  1  core access is a write.
- core_addr  in  32  core byte address (ALU result).
- core_wdata  in  32  core store data.
- core_gnt  out  1  core access performed this cycle (combinational).
- core_rdata  out  32  read data for core; equals mem_rd, combinational.
- core_stall  out  1  core_req & ~core_gnt; top level drives PC load = ~core_stall and gates RegWrite.
- host_req / host_we  in  1 / 1  host request and write qualifier; host holds req, we, addr and wdata stable until host_gnt.
- host_addr / host_wdata  in  32 / 32  host address and store data.
- host_gnt  out  1  host access performed this cycle (combinational).
- host_rdata  out  32  registered host read data.
- host_rvalid  out  1  one-cycle pulse: host_rdata holds data for the host read granted in the previous cycle.
- mem_we  out  1  data memory write enable.
- mem_addr / mem_wd  out  32 / 32  data memory address and write data.
- mem_rd  in  32  data memory combinational read data.
- stall_count  out  16  saturating count of cycles with core_stall high.

## Operation
- State: prio (0 = core owns priority, 1 = host), run (4-bit contended-grant counter), host_rdata, host_rvalid, stall_count.
- Arbitration (combinational, from current requests and registered prio):
  - Only core_req asserted: core wins.
  - Only host_req asserted: host wins.
  - Both asserted (contended): the current prio owner wins.
  - Neither asserted: no grant; mem_we = 0.
- The winner's addr, wdata and we drive mem_*. The loser's write never reaches mem_we. mem_addr and mem_wd default to the core's values when no grant is made.
- Quota update, contended cycles only: if run + 1 equals the owner's quota, prio toggles and run goes to 0. Otherwise run increments.
- Uncontended and idle cycles leave prio and run unchanged.
- Quota = 1: strict alternation under sustained contention.
- Host read: when host wins with host_we = 0, host_rdata <= mem_rd and host_rvalid <= 1 on the next edge. In all other cycles host_rvalid <= 0 and host_rdata holds its value.
- Host write: the data memory writes on the same edge. host_rvalid is not asserted.
- stall_count increments on every edge with core_stall = 1 and saturates at 0xFFFF.

## Timing
- Grant and memory routing take 0 cycles. A core load or store completes in the cycle it is granted, so there is no added latency when uncontended.
- Host read latency: data is in host_rdata 1 cycle after host_gnt, qualified by host_rvalid.
- Host write latency: the write commits on the edge that ends the host_gnt cycle.
- Worst-case core wait under continuous host traffic: HOST_QUOTA cycles.
- Worst-case host wait under continuous core traffic: CORE_QUOTA cycles.
- Reset (areset high at an edge): prio = 0, run = 0, host_rvalid = 0, host_rdata = 0, stall_count = 0.
- While areset is high, core_gnt, host_gnt, mem_we and core_stall are forced to 0. A host read granted in the cycle before reset produces no rvalid after reset.
- core_req with core_we = 0 and no store is still arbitrated, because loads occupy the port.

## Test plan
- Core-only store: core_req = 1, we = 1, addr = 0x10, wdata = 0xDEADBEEF -> core_gnt = 1, mem_we = 1 the same cycle, core_stall = 0; a following core load of 0x10 returns 0xDEADBEEF combinationally.
- Host read latency: host writes 0x12345678 to 0x20, then reads 0x20 -> host_gnt in cycle N, host_rvalid = 1 with host_rdata = 0x12345678 in cycle N+1 only.
- Sustained contention with default quotas, both requesting for 10 cycles -> grant sequence C,C,C,C,H,C,C,C,C,H; core_stall is high in cycles 5 and 10; stall_count = 2.
- Quota 1/1 contention -> strict C,H,C,H alternation. A host-only cycle inserted in the middle does not change the next contended winner.
- Loser write blocked: both write under contention to 0x30 (core 0x1, host 0x2) with prio = core -> memory holds 0x1 after the cycle; host write lands the next cycle (0x2).
- Mid-operation reset: assert areset during the host read grant cycle -> next cycle host_rvalid = 0, host_rdata = 0, prio = 0, stall_count = 0; mem_we = 0 while areset is high.
